// File: rtl/spi_adc_responder_pkg.sv
// Shared constants and FSM encoding for the SPI ADC responder and the
// controller that talks to it.
package spi_adc_responder_pkg;

    localparam int CMD_LEN     = 4;
    localparam int SAMPLE_W    = 10;
    localparam int RESP_LEN    = 2 * SAMPLE_W;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 5;

    localparam logic [CMD_LEN-1:0] EXPECT_CMD = 4'b1110;
    localparam logic [CNT_W-1:0]   FRAME_BITS = CNT_W'(CMD_LEN + RESP_LEN);
    localparam logic [CNT_W-1:0]   CMD_LAST   = CNT_W'(CMD_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_adc_responder_input_sync.sv
// Multi-flop synchronizer for one SPI pin, with single-cycle rise/fall pulses.
// Ports:
//   clk, rst_n     system clock, async active-low reset
//   i_d            asynchronous pin
//   o_level        synchronized level
//   o_rise/o_fall  one-cycle pulses on synchronized edges
// Resets to 0 so a pin already low when reset is released never looks like
// a fresh falling edge.
module spi_adc_responder_input_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI mode-0 target model of a two-channel 10-bit ADC.
// Receives a 4-bit command, answers with {ch1_sample, ch0_sample} MSB first.
// All SPI pins are oversampled on clk; nothing is clocked by sclk.
// Ports:
//   clk, rst_n              system clock, async active-low reset
//   sclk_i, cs_i, data_i    SPI pins from the controller
//   data_o, data_oe         response data and its output enable
//   ch0_sample, ch1_sample  parallel samples, snapshotted at CS fall
//   cmd_word, cmd_valid     last command and its completion pulse
//   cmd_error               command differed from EXPECT_CMD (level)
//   frame_done/frame_abort  CS-rise pulses for full / short-or-long frames
//   busy                    FSM outside IDLE
//
// state   | meaning
// IDLE    | waiting for CS fall
// CMD     | shifting in command bits on sclk rise
// RESP    | driving response bits on sclk fall
// HOLD    | response finished, output off, counting extra clocks
module spi_adc_responder
    import spi_adc_responder_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sclk_i,
    input  logic                cs_i,
    input  logic                data_i,
    output logic                data_o,
    output logic                data_oe,
    input  logic [SAMPLE_W-1:0] ch0_sample,
    input  logic [SAMPLE_W-1:0] ch1_sample,
    output logic [CMD_LEN-1:0]  cmd_word,
    output logic                cmd_valid,
    output logic                cmd_error,
    output logic                frame_done,
    output logic                frame_abort,
    output logic                busy
);

    logic w_sclk_rise, w_sclk_fall, w_unused_sclk_level;
    logic w_cs_rise, w_cs_fall, w_unused_cs_level;
    logic w_data_level, w_unused_data_rise, w_unused_data_fall;

    spi_adc_responder_input_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_d(sclk_i),
        .o_level(w_unused_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_adc_responder_input_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .i_d(cs_i),
        .o_level(w_unused_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spi_adc_responder_input_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
        .clk(clk), .rst_n(rst_n), .i_d(data_i),
        .o_level(w_data_level), .o_rise(w_unused_data_rise), .o_fall(w_unused_data_fall)
    );

    spi_state_t           r_state, w_state;
    logic [CNT_W-1:0]     r_cnt, w_cnt;
    logic [CMD_LEN-1:0]   r_cmd, w_cmd;
    logic [RESP_LEN-1:0]  r_resp, w_resp;
    logic                 r_data_o, w_data_o;
    logic                 r_err, w_err;
    logic                 r_valid, w_valid;
    logic                 r_done, w_done;
    logic                 r_abort, w_abort;
    logic [CMD_LEN-1:0]   w_cmd_shift;

    assign w_cmd_shift = {r_cmd[CMD_LEN-2:0], w_data_level};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_cmd    <= '0;
            r_resp   <= '0;
            r_data_o <= 1'b0;
            r_err    <= 1'b0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_abort  <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_cmd    <= w_cmd;
            r_resp   <= w_resp;
            r_data_o <= w_data_o;
            r_err    <= w_err;
            r_valid  <= w_valid;
            r_done   <= w_done;
            r_abort  <= w_abort;
        end
    end

    // r_cnt counts sclk rises for the whole frame, so a full frame ends at
    // FRAME_BITS and extra clocks in HOLD push it past that.
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_cmd    = r_cmd;
        w_resp   = r_resp;
        w_data_o = r_data_o;
        w_err    = r_err;
        w_valid  = 1'b0;
        w_done   = 1'b0;
        w_abort  = 1'b0;

        // CS rise has priority over any sclk edge seen in the same cycle.
        if (r_state != ST_IDLE && w_cs_rise) begin
            w_state  = ST_IDLE;
            w_data_o = 1'b0;
            if (r_state == ST_HOLD && r_cnt == FRAME_BITS) begin
                w_done = 1'b1;
            end else begin
                w_abort = 1'b1;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        w_state = ST_CMD;
                        w_resp  = {ch1_sample, ch0_sample};
                        w_cnt   = '0;
                        w_err   = 1'b0;
                    end
                end
                ST_CMD: begin
                    if (w_sclk_rise) begin
                        w_cmd = w_cmd_shift;
                        w_cnt = r_cnt + 1'b1;
                        if (r_cnt == CMD_LAST) begin
                            w_valid = 1'b1;
                            w_state = ST_RESP;
                            if (w_cmd_shift != EXPECT_CMD) begin
                                w_err  = 1'b1;
                                w_resp = '0;
                            end
                        end
                    end
                end
                ST_RESP: begin
                    if (w_sclk_rise) begin
                        w_cnt = r_cnt + 1'b1;
                    end
                    // The fall after the last rise retires the final bit.
                    if (w_sclk_fall) begin
                        if (r_cnt == FRAME_BITS) begin
                            w_state  = ST_HOLD;
                            w_data_o = 1'b0;
                        end else begin
                            w_data_o = r_resp[RESP_LEN-1];
                            w_resp   = {r_resp[RESP_LEN-2:0], 1'b0};
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_sclk_rise && r_cnt != '1) begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
                default: w_state = ST_IDLE;
            endcase
        end
    end

    assign data_o      = r_data_o;
    assign data_oe     = (r_state == ST_RESP);
    assign cmd_word    = r_cmd;
    assign cmd_valid   = r_valid;
    assign cmd_error   = r_err;
    assign frame_done  = r_done;
    assign frame_abort = r_abort;
    assign busy        = (r_state != ST_IDLE);

endmodule
